// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial RAM controller: FSM states,
// data-access width codes and the width-to-byte-count decode.
package mem_ctrl_pkg;

    localparam int LINE_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        DREAD,
        DWRITE,
        DONE
    } state_t;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    // Code 3 is reserved and behaves as a word access.
    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            MEM_B:   return 3'd1;
            MEM_H:   return 3'd2;
            MEM_W:   return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-side signals of the memory controller.
// slave = the controller, master = requesters plus the RAM.
interface mem_ctrl_if #(
    parameter int ADDR_W     = 17,
    parameter int LINE_BYTES = mem_ctrl_pkg::LINE_BYTES
);
    logic                    ram_inst_re;
    logic [31:0]             ram_inst_addr;
    logic [8*LINE_BYTES-1:0] ram_inst;
    logic                    ram_inst_busy;

    logic                    mem_re;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [1:0]              mem_width;
    logic [31:0]             mem_wdata;
    logic [31:0]             mem_rdata;
    logic                    mem_busy;

    logic [ADDR_W-1:0]       ram_a;
    logic [7:0]              ram_dout;
    logic                    ram_wr;
    logic [7:0]              ram_din;

    modport slave (
        input  ram_inst_re, ram_inst_addr,
        input  mem_re, mem_we, mem_addr, mem_width, mem_wdata,
        input  ram_din,
        output ram_inst, ram_inst_busy,
        output mem_rdata, mem_busy,
        output ram_a, ram_dout, ram_wr
    );

    modport master (
        output ram_inst_re, ram_inst_addr,
        output mem_re, mem_we, mem_addr, mem_width, mem_wdata,
        output ram_din,
        input  ram_inst, ram_inst_busy,
        input  mem_rdata, mem_busy,
        input  ram_a, ram_dout, ram_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Single-port byte RAM controller: arbitrates i-cache line fills against
// MEM-stage loads/stores and serialises each into little-endian byte accesses.
module mem_ctrl #(
    parameter int ADDR_W     = 17,
    parameter int LINE_BYTES = mem_ctrl_pkg::LINE_BYTES
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);
    import mem_ctrl_pkg::*;

    localparam int OFS_W  = $clog2(LINE_BYTES);
    localparam int CNT_W  = $clog2(LINE_BYTES + 2);
    localparam int LINE_W = 8 * LINE_BYTES;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          nbytes_q, nbytes_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
    logic [7:0]          ram_dout_q, ram_dout_d;
    logic                ram_wr_q, ram_wr_d;
    logic [LINE_W-1:0]   inst_q, inst_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ibusy_q, ibusy_d;
    logic                mbusy_q, mbusy_d;

    logic                stalled_q;
    logic [7:0]          din_hold_q;
    logic [7:0]          din;
    logic [CNT_W-1:0]    prev_k, next_k;
    logic [ADDR_W-1:0]   line_base;
    logic                unused_addr_bits;

    assign prev_k    = cnt_q - CNT_W'(1);
    assign next_k    = cnt_q + CNT_W'(1);
    assign line_base = {bus.ram_inst_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
    assign unused_addr_bits = ^{bus.ram_inst_addr[31:ADDR_W], bus.ram_inst_addr[OFS_W-1:0]};

    // The RAM keeps reading while we are stalled, so the byte that was due
    // when rdy dropped is parked here and used on the first edge after resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            stalled_q  <= 1'b0;
            din_hold_q <= '0;
        end else begin
            stalled_q <= !rdy;
            if (!rdy && !stalled_q)
                din_hold_q <= bus.ram_din;
        end
    end

    assign din = stalled_q ? din_hold_q : bus.ram_din;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nbytes_d   = nbytes_q;
        wdata_d    = wdata_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = ram_wr_q;
        inst_d     = inst_q;
        rdata_d    = rdata_q;
        ibusy_d    = ibusy_q;
        mbusy_d    = mbusy_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Data side is older in the pipe, so it wins; stores beat loads.
                if (bus.mem_we) begin
                    state_d    = DWRITE;
                    mbusy_d    = 1'b1;
                    nbytes_d   = width_bytes(bus.mem_width);
                    wdata_d    = bus.mem_wdata;
                    ram_a_d    = bus.mem_addr;
                    ram_dout_d = bus.mem_wdata[7:0];
                    ram_wr_d   = 1'b1;
                end else if (bus.mem_re) begin
                    state_d  = DREAD;
                    mbusy_d  = 1'b1;
                    nbytes_d = width_bytes(bus.mem_width);
                    ram_a_d  = bus.mem_addr;
                    rdata_d  = '0;
                end else if (bus.ram_inst_re) begin
                    state_d = IFETCH;
                    ibusy_d = 1'b1;
                    ram_a_d = line_base;
                end
            end

            // Byte k is addressed after edge k and captured at edge k+2.
            IFETCH: begin
                cnt_d = next_k;
                if (next_k < CNT_W'(LINE_BYTES))
                    ram_a_d = ram_a_q + ADDR_W'(1);
                if (cnt_q != '0)
                    inst_d[{prev_k[OFS_W-1:0], 3'b000} +: 8] = din;
                if (cnt_q == CNT_W'(LINE_BYTES)) begin
                    ibusy_d = 1'b0;
                    state_d = DONE;
                end
            end

            DREAD: begin
                cnt_d = next_k;
                if (next_k < CNT_W'(nbytes_q))
                    ram_a_d = ram_a_q + ADDR_W'(1);
                if (cnt_q != '0)
                    rdata_d[{prev_k[1:0], 3'b000} +: 8] = din;
                if (cnt_q == CNT_W'(nbytes_q)) begin
                    mbusy_d = 1'b0;
                    state_d = DONE;
                end
            end

            DWRITE: begin
                cnt_d = next_k;
                if (next_k < CNT_W'(nbytes_q)) begin
                    ram_a_d    = ram_a_q + ADDR_W'(1);
                    ram_dout_d = wdata_q[{next_k[1:0], 3'b000} +: 8];
                end else begin
                    ram_wr_d = 1'b0;
                    mbusy_d  = 1'b0;
                    state_d  = DONE;
                end
            end

            // Requester still holds its request this cycle; ignore it.
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nbytes_q   <= '0;
            wdata_q    <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            inst_q     <= '0;
            rdata_q    <= '0;
            ibusy_q    <= 1'b0;
            mbusy_q    <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            wdata_q    <= wdata_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
            inst_q     <= inst_d;
            rdata_q    <= rdata_d;
            ibusy_q    <= ibusy_d;
            mbusy_q    <= mbusy_d;
        end
    end

    assign bus.ram_inst      = inst_q;
    assign bus.ram_inst_busy = ibusy_q;
    assign bus.mem_rdata     = rdata_q;
    assign bus.mem_busy      = mbusy_q;
    assign bus.ram_a         = ram_a_q;
    assign bus.ram_dout      = ram_dout_q;
    assign bus.ram_wr        = ram_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: behavioural sync-read byte RAM, line fills,
// loads/stores, arbitration, rdy stalls and mid-transfer reset.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    always #5 clk = ~clk;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    localparam logic [127:0] LINE1 = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [127:0] LINE2 = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;

    logic [7:0]  ram [0:(1<<17)-1];
    logic        pre_we;
    logic [16:0] pre_a;
    logic [7:0]  pre_d;

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_a] <= pre_d;
        else if (bus.ram_wr)
            ram[bus.ram_a] <= bus.ram_dout;
        bus.ram_din <= ram[bus.ram_a];
    end

    int ncyc     = 0;
    int wr_total = 0;
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (bus.ram_wr)
            wr_total <= wr_total + 1;
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Raise a request, count busy cycles, drop one cycle after busy falls.
    task automatic run_inst(input logic [31:0] a, output int cyc, output int first);
        bus.ram_inst_addr = a;
        bus.ram_inst_re   = 1'b1;
        cyc   = 0;
        first = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ram_inst_busy) begin
                if (cyc == 0) first = ncyc;
                cyc++;
            end else if (cyc > 0) break;
        end
        @(negedge clk);
        bus.ram_inst_re = 1'b0;
    endtask

    task automatic run_mem(input logic we, input logic [16:0] a, input logic [1:0] w,
                           input logic [31:0] wd, output int cyc, output int first);
        bus.mem_addr  = a;
        bus.mem_width = w;
        bus.mem_wdata = wd;
        bus.mem_we    = we;
        bus.mem_re    = !we;
        cyc   = 0;
        first = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.mem_busy) begin
                if (cyc == 0) first = ncyc;
                cyc++;
            end else if (cyc > 0) break;
        end
        @(negedge clk);
        bus.mem_we = 1'b0;
        bus.mem_re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, f, c2, f2, w0;
        rst = 1'b1;
        rdy = 1'b1;
        pre_we = 1'b0;
        pre_a  = '0;
        pre_d  = '0;
        bus.ram_inst_re   = 1'b0;
        bus.ram_inst_addr = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_width = '0;
        bus.mem_wdata = '0;
        repeat (2) @(negedge clk);

        chk("rst_inst",  bus.ram_inst, 128'h0);
        chk("rst_rdata", bus.mem_rdata, 128'h0);
        chk("rst_ibusy", bus.ram_inst_busy, 128'h0);
        chk("rst_mbusy", bus.mem_busy, 128'h0);
        chk("rst_wr",    bus.ram_wr, 128'h0);
        chk("rst_a",     bus.ram_a, 128'h0);
        chk("rst_dout",  bus.ram_dout, 128'h0);
        rst = 1'b0;

        // Line fill from an unaligned address within the line
        for (int k = 0; k < 16; k++) poke(17'h100 + 17'(k), 8'h10 + 8'(k));
        run_inst(32'h108, c, f);
        chk("if_busy_cycles", c, 17);
        chk("if_data", bus.ram_inst, LINE1);
        repeat (3) @(negedge clk);
        chk("if_no_reaccept", bus.ram_inst_busy, 0);

        // Word load
        poke(17'h2000, 8'hEF); poke(17'h2001, 8'hBE);
        poke(17'h2002, 8'hAD); poke(17'h2003, 8'hDE);
        run_mem(1'b0, 17'h2000, 2'd2, 32'h0, c, f);
        chk("ldw_busy_cycles", c, 5);
        chk("ldw_data", bus.mem_rdata, 32'hDEADBEEF);
        chk("ldw_inst_held", bus.ram_inst, LINE1);

        // Misaligned half store, then byte load from its upper byte
        w0 = wr_total;
        run_mem(1'b1, 17'h0301, 2'd1, 32'h0000A55A, c, f);
        chk("sth_busy_cycles", c, 2);
        chk("sth_wr_cycles", wr_total - w0, 2);
        chk("sth_ram301", ram[17'h301], 8'h5A);
        chk("sth_ram302", ram[17'h302], 8'hA5);
        run_mem(1'b0, 17'h0302, 2'd0, 32'h0, c, f);
        chk("ldb_busy_cycles", c, 2);
        chk("ldb_data", bus.mem_rdata, 32'h000000A5);

        // Simultaneous requests: the data load goes first
        for (int k = 0; k < 16; k++) poke(17'h400 + 17'(k), 8'hA0 + 8'(k));
        poke(17'h500, 8'h44); poke(17'h501, 8'h33);
        poke(17'h502, 8'h22); poke(17'h503, 8'h11);
        fork
            run_inst(32'h400, c, f);
            run_mem(1'b0, 17'h0500, 2'd2, 32'h0, c2, f2);
        join
        chk("arb_mem_cycles", c2, 5);
        chk("arb_inst_cycles", c, 17);
        chk("arb_order", f - f2, 7);
        chk("arb_mem_data", bus.mem_rdata, 32'h11223344);
        chk("arb_inst_data", bus.ram_inst, LINE2);

        // Three stalled cycles in the middle of a line fill
        w0 = wr_total;
        fork
            run_inst(32'h100, c, f);
            begin
                repeat (6) @(negedge clk);
                rdy = 1'b0;
                repeat (3) @(negedge clk);
                rdy = 1'b1;
            end
        join
        chk("stall_if_cycles", c, 20);
        chk("stall_if_data", bus.ram_inst, LINE1);
        chk("stall_if_no_wr", wr_total - w0, 0);

        // Word store: stall once, then reset before it completes
        poke(17'h603, 8'h99);
        @(negedge clk);
        bus.mem_addr  = 17'h0600;
        bus.mem_width = 2'd2;
        bus.mem_wdata = 32'h12345678;
        bus.mem_we    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        chk("stall_st_wr", bus.ram_wr, 0);
        chk("stall_st_busy", bus.mem_busy, 1);
        rdy = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        bus.mem_we = 1'b0;
        @(negedge clk);
        chk("abort_mbusy", bus.mem_busy, 0);
        chk("abort_ibusy", bus.ram_inst_busy, 0);
        chk("abort_wr", bus.ram_wr, 0);
        chk("abort_a", bus.ram_a, 0);
        chk("abort_rdata", bus.mem_rdata, 0);
        chk("abort_ram601", ram[17'h601], 8'h56);
        chk("abort_ram603", ram[17'h603], 8'h99);
        rst = 1'b0;
        run_mem(1'b0, 17'h0302, 2'd0, 32'h0, c, f);
        chk("post_rst_busy_cycles", c, 2);
        chk("post_rst_data", bus.mem_rdata, 32'h000000A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
